// File: rtl/change_event_recorder.sv
// Change event recorder: samples an NBITS signal every clock, records each
// sampled value change as {value, timestamp} into a FIFO, and drains the
// records through a valid/ready stream. Change/drop counters and a sticky
// overflow flag let a checker reconcile detected changes with lost ones.
module change_event_recorder #(
  parameter int NBITS = 33,
  parameter int TS_W  = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     enable,
  input  logic [NBITS-1:0]         sig,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NBITS-1:0]         out_value,
  output logic [TS_W-1:0]          out_time,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [31:0]              change_count,
  output logic [15:0]              drop_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  typedef struct packed {
    logic [NBITS-1:0] value;
    logic [TS_W-1:0]  ts;
  } rec_t;

  rec_t             mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      level;
  logic [TS_W-1:0]  ts;
  logic [NBITS-1:0] prev;
  logic             prev_valid;

  logic full, pop, evt, push, drop;

  // Handshake and event qualification; clear suppresses both pop and event.
  always_comb begin
    full = (level == FULL_LVL);
    pop  = out_valid && out_ready && !clear;
    evt  = enable && prev_valid && (sig != prev) && !clear;
    // A full FIFO still takes the record when the head leaves this cycle.
    push = evt && (!full || pop);
    drop = evt && full && !pop;
  end

  assign out_valid  = (level != '0);
  assign fifo_level = level;
  // Head record presented only while valid; zero otherwise.
  assign out_value  = out_valid ? mem[rd_ptr].value : '0;
  assign out_time   = out_valid ? mem[rd_ptr].ts    : '0;

  // Free-running timestamp and the baseline/previous-sample tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts         <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (clear) begin
      ts         <= '0;
      prev_valid <= 1'b0;
    end else begin
      ts <= ts + TS_W'(1);
      if (enable) begin
        // First enabled edge only captures a baseline; later edges follow changes.
        if (!prev_valid || evt) prev <= sig;
        prev_valid <= 1'b1;
      end else begin
        prev_valid <= 1'b0;
      end
    end
  end

  // FIFO storage; contents need no reset since out_valid gates the outputs.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{value: sig, ts: ts};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Saturating change/drop counters and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      change_count <= '0;
      drop_count   <= '0;
      overflow     <= 1'b0;
    end else if (clear) begin
      change_count <= '0;
      drop_count   <= '0;
      overflow     <= 1'b0;
    end else begin
      if (evt && change_count != '1) change_count <= change_count + 32'd1;
      if (drop && drop_count != '1)  drop_count   <= drop_count + 16'd1;
      if (drop)                      overflow     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_change_event_recorder.sv
// Randomised and directed bench for change_event_recorder, checked every
// cycle against a queue-based behavioural model plus literal expectations.
module tb_change_event_recorder;
  localparam int NBITS = 33;
  localparam int TS_W  = 32;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              enable = 1'b0;
  logic [NBITS-1:0]  sig = '0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [NBITS-1:0]  out_value;
  logic [TS_W-1:0]   out_time;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [31:0]       change_count;
  logic [15:0]       drop_count;
  logic              overflow;

  change_event_recorder #(.NBITS(NBITS), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .enable(enable), .sig(sig),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
    .out_time(out_time), .fifo_level(fifo_level), .change_count(change_count),
    .drop_count(drop_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [NBITS-1:0] v;
    logic [TS_W-1:0]  t;
  } rec_t;

  rec_t             mq[$];
  logic [TS_W-1:0]  m_ts   = '0;
  logic [NBITS-1:0] m_prev = '0;
  logic             m_pv   = 1'b0;
  logic [31:0]      m_cc   = '0;
  logic [15:0]      m_dc   = '0;
  logic             m_ovf  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete(); m_ts = '0; m_pv = 1'b0; m_cc = '0; m_dc = '0; m_ovf = 1'b0;
    end else if (clear) begin
      mq.delete(); m_ts = '0; m_pv = 1'b0; m_cc = '0; m_dc = '0; m_ovf = 1'b0;
    end else begin
      logic ev;
      rec_t r;
      ev = enable && m_pv && (sig != m_prev);
      if (enable) begin
        m_prev = sig;   // baseline or followed change; equal otherwise
        m_pv   = 1'b1;
      end else begin
        m_pv = 1'b0;
      end
      if (mq.size() != 0 && out_ready) r = mq.pop_front();
      if (ev) begin
        if (m_cc != 32'hFFFF_FFFF) m_cc++;
        if (mq.size() < DEPTH) mq.push_back('{sig, m_ts});
        else begin
          if (m_dc != 16'hFFFF) m_dc++;
          m_ovf = 1'b1;
        end
      end
      m_ts++;
    end
  end

  // ---------------- per-cycle compare + observers ----------------
  rec_t dut_pops[$];
  int   vcnt = 0;
  int   maxlvl = 0;
  logic p_valid = 1'b0, p_ready = 1'b0, p_clear = 1'b0, p_rst = 1'b0;
  logic [NBITS-1:0] p_val = '0;
  logic [TS_W-1:0]  p_time = '0;

  always @(negedge clk) begin
    logic [NBITS-1:0] ev_v;
    logic [TS_W-1:0]  ev_t;
    ev_v = (mq.size() != 0) ? mq[0].v : '0;
    ev_t = (mq.size() != 0) ? mq[0].t : '0;
    chk("out_valid",    out_valid,    mq.size() != 0);
    chk("out_value",    out_value,    ev_v);
    chk("out_time",     out_time,     ev_t);
    chk("fifo_level",   fifo_level,   mq.size());
    chk("change_count", change_count, m_cc);
    chk("drop_count",   drop_count,   m_dc);
    chk("overflow",     overflow,     m_ovf);
    if (rst_n && p_rst && p_valid && !p_ready && !p_clear) begin
      chk("stall_value", out_value, p_val);
      chk("stall_time",  out_time,  p_time);
    end
    if (rst_n && out_valid && out_ready && !clear) dut_pops.push_back('{out_value, out_time});
    if (out_valid) vcnt++;
    if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
    p_valid = out_valid; p_ready = out_ready; p_clear = clear; p_rst = rst_n;
    p_val = out_value; p_time = out_time;
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_clear();
    clear = 1'b1; cyc(1); clear = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [NBITS-1:0] j;
    int errs;

    // Reset held: activity on inputs must not show.
    for (int i = 0; i < 4; i++) begin
      enable = i[0]; sig = NBITS'($urandom); out_ready = 1'b1; cyc(1);
    end
    chk("rst_valid", out_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_cc", change_count, 0);

    // Single change: baseline at ts=3, change sampled at ts=10.
    enable = 1'b0; sig = '0; out_ready = 1'b1;
    rst_n = 1'b1;
    vcnt = 0; dut_pops.delete();
    cyc(3);
    enable = 1'b1; cyc(1);
    cyc(6);
    sig = NBITS'(5); cyc(1);
    chk("single_valid", out_valid, 1);
    chk("single_time_now", out_time, 10);
    cyc(3);
    chk("single_vcnt", vcnt, 1);
    chk("single_pops", dut_pops.size(), 1);
    if (dut_pops.size() == 1) begin
      chk("single_value", dut_pops[0].v, 5);
      chk("single_time", dut_pops[0].t, 10);
    end
    chk("single_cc", change_count, 1);

    // Johnson counter, one change per clock, consumer always ready.
    do_clear();
    sig = '0; enable = 1'b1; cyc(1);
    dut_pops.delete(); maxlvl = 0; j = '0;
    for (int i = 0; i < 200; i++) begin
      j = {~j[0], j[NBITS-1:1]}; sig = j; cyc(1);
    end
    cyc(3);
    chk("john_cc", change_count, 200);
    chk("john_dc", drop_count, 0);
    chk("john_pops", dut_pops.size(), 200);
    chk("john_maxlvl", maxlvl <= 1, 1);
    errs = 0; j = '0;
    for (int i = 0; i < dut_pops.size(); i++) begin
      j = {~j[0], j[NBITS-1:1]};
      if (dut_pops[i].v !== j || dut_pops[i].t !== TS_W'(i + 1)) errs++;
    end
    chk("john_order", errs, 0);

    // Overflow: 20 changes into a stalled 16-deep FIFO.
    do_clear();
    out_ready = 1'b0; sig = '0; enable = 1'b1; cyc(1);
    for (int i = 1; i <= 20; i++) begin sig = NBITS'(i); cyc(1); end
    chk("ovf_level", fifo_level, 16);
    chk("ovf_cc", change_count, 20);
    chk("ovf_dc", drop_count, 4);
    chk("ovf_flag", overflow, 1);
    dut_pops.delete(); out_ready = 1'b1; cyc(18);
    chk("ovf_pops", dut_pops.size(), 16);
    errs = 0;
    for (int i = 0; i < dut_pops.size(); i++) if (dut_pops[i].v !== NBITS'(i + 1)) errs++;
    chk("ovf_order", errs, 0);
    chk("ovf_sticky", overflow, 1);
    chk("ovf_drained", fifo_level, 0);

    // Full FIFO, pop and push in the same cycle; then 1010 backpressure.
    do_clear();
    out_ready = 1'b0; sig = '0; enable = 1'b1; cyc(1);
    for (int i = 1; i <= 16; i++) begin sig = NBITS'(i); cyc(1); end
    chk("full_level", fifo_level, 16);
    out_ready = 1'b1; sig = NBITS'(100); cyc(1);
    chk("full_pp_level", fifo_level, 16);
    chk("full_pp_dc", drop_count, 0);
    chk("full_pp_cc", change_count, 17);
    for (int k = 0; k < 8; k++) begin out_ready = (k % 2 == 0); cyc(1); end
    out_ready = 1'b1; cyc(20);

    // Enable low then re-enabled: re-baseline, no record.
    do_clear();
    out_ready = 1'b1; sig = '0; enable = 1'b1; cyc(3);
    enable = 1'b0; sig = NBITS'(7); cyc(2);
    enable = 1'b1; cyc(3);
    chk("reen_cc", change_count, 0);
    chk("reen_level", fifo_level, 0);
    sig = NBITS'(9); cyc(1);
    chk("reen_change", change_count, 1);
    // Clear coinciding with an event.
    out_ready = 1'b0; sig = NBITS'(11); clear = 1'b1; cyc(1); clear = 1'b0;
    chk("clr_cc", change_count, 0);
    chk("clr_level", fifo_level, 0);
    chk("clr_ovf", overflow, 0);

    // Asynchronous reset mid-stream with level 5.
    sig = '0; cyc(1);
    for (int i = 1; i <= 5; i++) begin sig = NBITS'(i + 20); cyc(1); end
    chk("mid_level", fifo_level, 5);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_cc", change_count, 0);
    cyc(2);
    rst_n = 1'b1;

    // Randomised traffic: small value alphabet to get repeats, stall bursts.
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom % 8) != 0;
      if ($urandom % 3 != 0)
        sig = NBITS'($urandom_range(0, 3)) | (NBITS'($urandom_range(0, 1)) << (NBITS - 1));
      out_ready = (i % 400 < 100) ? ($urandom % 6 == 0) : ($urandom % 3 != 0);
      clear = ($urandom % 250 == 0);
      cyc(1);
    end
    clear = 1'b0; out_ready = 1'b1; cyc(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
